bmp_gray_engine: RTL

Synthesizable controller on the initiator side of the BMP loader/saver start/done handshake. It asks the BMP loader to place a 24-bpp image in byte-addressed frame memory. It then converts every pixel to grey through a single frame-memory port and writes the result to a destination region. Finally it asks the BMP saver to write that region back to a file. It sits between the testbench BMP model and the shared frame memory, and is the first real datapath block in the image pipeline.

---
 rtl/bmp_pkg.sv | 49 ++++
 rtl/bmp_luma.sv | 26 ++
 rtl/bmp_gray_engine.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmp_pkg
// Description : Shared definitions for the BMP grey-conversion engine: FSM
//               state encoding, luma coefficients and 24-bpp row-stride
//               helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package bmp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LD_REQ = 4'd1,
        ST_LD_REL = 4'd2,
        ST_RD_B   = 4'd3,
        ST_RD_G   = 4'd4,
        ST_RD_R   = 4'd5,
        ST_CALC   = 4'd6,
        ST_WR_B   = 4'd7,
        ST_WR_G   = 4'd8,
        ST_WR_R   = 4'd9,
        ST_WR_PAD = 4'd10,
        ST_SV_REQ = 4'd11,
        ST_SV_REL = 4'd12,
        ST_FIN    = 4'd13
    } state_t;

    // Fixed-point BT.601-style weights; they sum to 256 so the result of the
    // weighted sum shifted right by 8 can never exceed 255.
    localparam logic [7:0] C_COEF_R = 8'd77;
    localparam logic [7:0] C_COEF_G = 8'd150;
    localparam logic [7:0] C_COEF_B = 8'd29;

    // Bytes per BMP row: 3 bytes per pixel rounded up to a 4-byte boundary.
    function automatic logic [31:0] row_stride(input logic [15:0] width);
        logic [31:0] w_bytes;
        w_bytes = {16'd0, width} * 32'd3;
        return (w_bytes + 32'd3) & ~32'd3;
    endfunction

    // Number of zero pad bytes at the end of each row (0..3).
    function automatic logic [1:0] row_pad(input logic [15:0] width);
        logic [31:0] w_bytes;
        w_bytes = {16'd0, width} * 32'd3;
        return 2'(row_stride(width) - w_bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmp_luma.sv
`default_nettype none
// ============================================================================
// Module      : bmp_luma
// Description : Combinational RGB to grey conversion,
//               y = (77*r + 150*g + 29*b) >> 8.
// Ports       : r, g, b  - 8-bit colour components
//               y        - 8-bit grey value
// Revision    : 1.0 - initial release
// ============================================================================
import bmp_pkg::*;

module bmp_luma (
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] y
);

    // The 16-bit weighted sum never overflows (max 256*255), so the top byte
    // is the result directly.
    assign y = 8'((({8'd0, C_COEF_R} * {8'd0, r})
                 + ({8'd0, C_COEF_G} * {8'd0, g})
                 + ({8'd0, C_COEF_B} * {8'd0, b})) >> 8);

endmodule
`default_nettype wire

// File: rtl/bmp_gray_engine.sv
`default_nettype none
// ============================================================================
// Module      : bmp_gray_engine
// Description : Job controller: requests a BMP load into frame memory,
//               converts every 24-bpp pixel to grey through one byte-wide
//               memory port, writes the grey bitmap (same layout, pad bytes
//               zeroed) to the destination region, then requests a save.
// Ports       : clk, reset_n            - clock, async active-low reset
//               go / busy / done        - job start, in-progress, end pulse
//               bmp_input_*             - load handshake and source address
//               bmp_output_*            - save handshake and dest address
//               bmp_width / bmp_height  - image size, bits [15:0] used
//               mem_*                   - byte frame-memory port
// Revision    : 1.0 - initial release
// ============================================================================
import bmp_pkg::*;

module bmp_gray_engine #(
    parameter logic [31:0] SRC_ADDR = 32'h0000_0000,
    parameter logic [31:0] DST_ADDR = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic        bmp_input_start,
    input  logic        bmp_input_done,
    output logic [31:0] bmp_input_address,
    output logic        bmp_output_start,
    input  logic        bmp_output_done,
    output logic [31:0] bmp_output_address,
    input  logic [31:0] bmp_width,
    input  logic [31:0] bmp_height,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata
);

    state_t      r_state;
    state_t      w_next;

    logic        r_pend;
    logic        r_in_start;
    logic        r_out_start;
    logic        r_rd_acc;
    logic [15:0] r_w;
    logic [15:0] r_h;
    logic [1:0]  r_pad;
    logic [31:0] r_off;
    logic [15:0] r_col;
    logic [15:0] r_row;
    logic [1:0]  r_pad_cnt;
    logic [7:0]  r_b;
    logic [7:0]  r_g;
    logic [7:0]  r_y;

    logic        w_accept;
    logic        w_last_col;
    logic        w_last_row;
    logic        w_last_pad;
    logic        w_size_zero;
    logic [7:0]  w_y;
    logic [31:0] w_unused_hi;

    assign w_unused_hi = {bmp_width[31:16], bmp_height[31:16]};

    assign bmp_input_address  = SRC_ADDR;
    assign bmp_output_address = DST_ADDR;
    assign bmp_input_start    = r_in_start;
    assign bmp_output_start   = r_out_start;

    assign busy        = r_pend || ((r_state != ST_IDLE) && (r_state != ST_FIN));
    assign w_accept    = mem_req && mem_ready;
    assign w_last_col  = (r_col + 16'd1) == r_w;
    assign w_last_row  = (r_row + 16'd1) == r_h;
    assign w_last_pad  = (r_pad_cnt + 2'd1) == r_pad;
    assign w_size_zero = (bmp_width[15:0] == 16'd0) || (bmp_height[15:0] == 16'd0);

    // Red is consumed straight from the memory bus in CALC, the cycle its
    // read data is valid, so only blue and green need holding registers.
    bmp_luma u_luma (
        .r (mem_rdata),
        .g (r_g),
        .b (r_b),
        .y (w_y)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // Both acknowledges must be low so a stale done cannot close
                // the handshake of a new job.
                if (r_pend && !bmp_input_done && !bmp_output_done) begin
                    w_next = ST_LD_REQ;
                end
            end
            ST_LD_REQ: begin
                if (r_in_start && bmp_input_done) begin
                    w_next = ST_LD_REL;
                end
            end
            ST_LD_REL: begin
                if (!bmp_input_done) begin
                    w_next = w_size_zero ? ST_SV_REQ : ST_RD_B;
                end
            end
            ST_RD_B: if (w_accept) w_next = ST_RD_G;
            ST_RD_G: if (w_accept) w_next = ST_RD_R;
            ST_RD_R: if (w_accept) w_next = ST_CALC;
            ST_CALC: w_next = ST_WR_B;
            ST_WR_B: if (w_accept) w_next = ST_WR_G;
            ST_WR_G: if (w_accept) w_next = ST_WR_R;
            ST_WR_R: begin
                if (w_accept) begin
                    if (!w_last_col) begin
                        w_next = ST_RD_B;
                    end else if (r_pad != 2'd0) begin
                        w_next = ST_WR_PAD;
                    end else begin
                        w_next = w_last_row ? ST_SV_REQ : ST_RD_B;
                    end
                end
            end
            ST_WR_PAD: begin
                if (w_accept && w_last_pad) begin
                    w_next = w_last_row ? ST_SV_REQ : ST_RD_B;
                end
            end
            ST_SV_REQ: begin
                if (r_out_start && bmp_output_done) begin
                    w_next = ST_SV_REL;
                end
            end
            ST_SV_REL: if (!bmp_output_done) w_next = ST_FIN;
            ST_FIN:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 8'd0;
        done      = 1'b0;
        case (r_state)
            ST_RD_B: begin
                mem_req  = 1'b1;
                mem_addr = SRC_ADDR + r_off;
            end
            ST_RD_G: begin
                mem_req  = 1'b1;
                mem_addr = SRC_ADDR + r_off + 32'd1;
            end
            ST_RD_R: begin
                mem_req  = 1'b1;
                mem_addr = SRC_ADDR + r_off + 32'd2;
            end
            ST_WR_B: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = DST_ADDR + r_off;
                mem_wdata = r_y;
            end
            ST_WR_G: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = DST_ADDR + r_off + 32'd1;
                mem_wdata = r_y;
            end
            ST_WR_R: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = DST_ADDR + r_off + 32'd2;
                mem_wdata = r_y;
            end
            ST_WR_PAD: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = DST_ADDR + r_off;
            end
            ST_FIN: done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------ datapath and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend      <= 1'b0;
            r_in_start  <= 1'b0;
            r_out_start <= 1'b0;
            r_rd_acc    <= 1'b0;
            r_w         <= 16'd0;
            r_h         <= 16'd0;
            r_pad       <= 2'd0;
            r_off       <= 32'd0;
            r_col       <= 16'd0;
            r_row       <= 16'd0;
            r_pad_cnt   <= 2'd0;
            r_b         <= 8'd0;
            r_g         <= 8'd0;
            r_y         <= 8'd0;
        end else begin
            if ((r_state == ST_IDLE) && (w_next == ST_LD_REQ)) begin
                r_pend <= 1'b0;
            end else if (go && !busy) begin
                r_pend <= 1'b1;
            end

            // Start goes high one cycle into the REQ state and falls as soon
            // as the acknowledge is seen; it is never raised while the
            // acknowledge is already high.
            r_in_start  <= (r_state == ST_LD_REQ) && !bmp_input_done;
            r_out_start <= (r_state == ST_SV_REQ) && !bmp_output_done;

            // Marks the single cycle in which read data is on mem_rdata.
            r_rd_acc <= w_accept && !mem_we;

            if ((r_state == ST_LD_REL) && !bmp_input_done) begin
                r_w       <= bmp_width[15:0];
                r_h       <= bmp_height[15:0];
                r_pad     <= row_pad(bmp_width[15:0]);
                r_off     <= 32'd0;
                r_col     <= 16'd0;
                r_row     <= 16'd0;
                r_pad_cnt <= 2'd0;
            end

            if (r_rd_acc) begin
                case (r_state)
                    ST_RD_G: r_b <= mem_rdata;
                    ST_RD_R: r_g <= mem_rdata;
                    ST_CALC: r_y <= w_y;
                    default: ;
                endcase
            end

            if ((r_state == ST_WR_R) && w_accept) begin
                r_off <= r_off + 32'd3;
                if (w_last_col) begin
                    r_col <= 16'd0;
                    if (r_pad == 2'd0) begin
                        r_row <= r_row + 16'd1;
                    end
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end

            if ((r_state == ST_WR_PAD) && w_accept) begin
                r_off <= r_off + 32'd1;
                if (w_last_pad) begin
                    r_pad_cnt <= 2'd0;
                    r_row     <= r_row + 16'd1;
                end else begin
                    r_pad_cnt <= r_pad_cnt + 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
